lsu_mem_map: RTL and testbench
==============================

LSU_MEM_MAP -- requirements
Module: lsu_mem_map

Interface
REQ-001 SHALL have parameter DATA_MEM_DEPTH, 1024, data RAM size in bytes (power of 2); lower half is .data, upper half is stack (DIV = DATA_MEM_DEPTH/2).
REQ-002 SHALL have parameter MMIO_MEM_SIZE, 8, MMIO window size in bytes starting at MMIO_LOWER (0x10010024).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_funct3 in 3 (RV32I load/store funct3), req_addr in 32, req_wdata in 32.
REQ-006 SHALL have ports rsp_valid out 1, rsp_rdata out 32, rsp_err out 1.
REQ-007 SHALL have ports ram_en out 1, ram_we out 4 (byte mask), ram_addr out log2(DATA_MEM_DEPTH)-2 (word index), ram_wdata out 32, ram_rdata in 32 (sync RAM, data valid cycle after ram_en).
REQ-008 SHALL have ports gpio_out out 8, gpio_in in 8.

Function
REQ-009 SHALL implement FSM IDLE, RD_WAIT, RESP; req_ready=1 only in IDLE; accept = req_valid & req_ready at rising edge.
REQ-010 Decode priority SHALL be: MMIO [0x10010024, +MMIO_MEM_SIZE), then data [0x10010000, +DIV), then stack [STACK_BASE, 0x7FFFF000) with STACK_BASE = 0x7FFFF000-DIV; anything else unmapped.
REQ-011 RAM byte offset SHALL be addr-0x10010000 for data, DIV+(addr-STACK_BASE) for stack; ram_addr = offset[..:2].
REQ-012 Error SHALL be flagged for: unmapped address; funct3 not in {000,001,010,100,101} for loads or not in {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-013 In IDLE with req_valid and RAM hit and no error, ram_en SHALL be 1 combinationally, ram_addr/ram_wdata/ram_we driven same cycle; otherwise ram_en=0, ram_we=0.
REQ-014 Store byte lanes: SB ram_we=1<<addr[1:0], wdata byte replicated to all lanes; SH ram_we=0011 or 1100 by addr[1], halfword replicated; SW ram_we=1111, wdata unchanged.
REQ-015 Load RAM: accept -> RD_WAIT; in RD_WAIT capture ram_rdata, select lane by latched addr[1:0], LB/LH sign-extend, LBU/LHU zero-extend, LW full word, into rsp_rdata -> RESP.
REQ-016 Store RAM, MMIO access, or error: accept -> RESP directly (rsp_valid one cycle after accept edge); load RAM: rsp_valid two cycles after accept edge.
REQ-017 RESP SHALL assert rsp_valid for exactly one cycle then return to IDLE; no response backpressure.
REQ-018 MMIO offset 0 SHALL be gpio_out register (R/W, byte 0 of word); offset 4 SHALL read gpio_in zero-extended as word, writes ignored; other MMIO offsets read 0, writes ignored.
REQ-019 MMIO store SHALL update gpio_out at the accept edge from req_wdata[7:0] for SB/SH/SW at offset 0; MMIO load data registered at accept edge, formatted per REQ-015.
REQ-020 On error rsp_err=1, rsp_rdata=0, no RAM or gpio_out side effect; stores return rsp_rdata=0, rsp_err=0.
REQ-021 rsp_rdata and rsp_err SHALL hold value until next response is produced.

Reset
REQ-022 rst asserted SHALL immediately force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, req_ready=1 after release.
REQ-023 Reset during RD_WAIT or RESP SHALL drop the in-flight response; no rsp_valid generated for it.

Verification
REQ-024 SW 0x10010000 wdata 0xDEADBEEF -> ram_en=1, ram_we=1111, ram_addr=0; rsp_valid next cycle, rsp_err=0.
REQ-025 LB 0x10010003 with ram_rdata 0xDEADBEEF -> rsp_valid 2 cycles after accept, rsp_rdata 0xFFFFFFDE; LBU same -> 0x000000DE; LH 0x10010002 -> 0xFFFFDEAD.
REQ-026 SW 0x7FFFEFFC -> ram_addr=255 (DATA_MEM_DEPTH=1024), ram_we=1111; SB 0x7FFFEE01 -> ram_addr=128, ram_we=0010.
REQ-027 SB 0x10010024 wdata 0x5A -> gpio_out=0x5A, no ram_en; LW 0x10010028 with gpio_in=0x3C -> rsp_rdata 0x0000003C.
REQ-028 LW 0x10010002, LH 0x10010001, SW 0x00000000, funct3=011 -> rsp_err=1, ram_en=0, gpio_out unchanged.
REQ-029 Assert rst in RD_WAIT -> rsp_valid stays 0, state IDLE, gpio_out=0; next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_map.sv
// rtl/lsu_mem_map.sv - load/store unit address decoder for data RAM, stack RAM and GPIO MMIO
//
// Purpose: decodes RV32I load/store requests into byte-lane accesses on a
// synchronous data RAM. The lower half of the RAM holds .data and the upper
// half holds the stack. A small MMIO window holds the GPIO registers.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_we, req_funct3           store flag and RV32I width/sign code
//   req_addr, req_wdata          byte address and store data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response pulse; data and error flag hold
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata  sync RAM port (word index, byte mask)
//   gpio_out, gpio_in            GPIO output register and input pins
module lsu_mem_map #(
  parameter int DATA_MEM_DEPTH = 1024,
  parameter int MMIO_MEM_SIZE  = 8,
  localparam int AW = $clog2(DATA_MEM_DEPTH) - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [7:0]    gpio_out,
  input  logic [7:0]    gpio_in
);

  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_LOWER = 32'h1001_0024;
  localparam logic [31:0] STACK_TOP  = 32'h7FFF_F000;
  localparam logic [31:0] DIV        = 32'(DATA_MEM_DEPTH / 2);
  localparam logic [31:0] STACK_BASE = STACK_TOP - DIV;
  localparam logic [31:0] DATA_UPPER = DATA_BASE + DIV;
  localparam logic [31:0] MMIO_UPPER = MMIO_LOWER + 32'(MMIO_MEM_SIZE);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state, state_next;

  logic        mmio_hit, data_hit, stack_hit, ram_hit;
  logic        f3_ok, misalign, err;
  logic [31:0] mmio_off, mmio_word;
  logic [3:0]  lane_mask;
  logic [1:0]  lat_lane;
  logic [2:0]  lat_f3;
  logic        accept;

  // Lane select plus sign/zero extension shared by RAM and MMIO loads.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // MMIO wins over .data where the windows overlap.
  always_comb begin
    mmio_hit  = (req_addr >= MMIO_LOWER) && (req_addr < MMIO_UPPER);
    data_hit  = !mmio_hit && (req_addr >= DATA_BASE) && (req_addr < DATA_UPPER);
    stack_hit = !mmio_hit && !data_hit && (req_addr >= STACK_BASE) && (req_addr < STACK_TOP);
    ram_hit   = data_hit || stack_hit;
    mmio_off  = req_addr - MMIO_LOWER;
  end

  always_comb begin
    f3_ok    = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                      : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    err      = !(mmio_hit || ram_hit) || !f3_ok || misalign;
  end

  // Word-granular offset arithmetic: the bases are word aligned, so only the
  // index bits matter and the subtraction wraps harmlessly above them.
  always_comb begin
    if (data_hit)
      ram_addr = req_addr[AW+1:2] - DATA_BASE[AW+1:2];
    else
      ram_addr = DIV[AW+1:2] + (req_addr[AW+1:2] - STACK_BASE[AW+1:2]);
  end

  always_comb begin
    lane_mask = 4'b0000;
    ram_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        ram_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{req_wdata[15:0]}};
      end
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    if (mmio_off < 32'd4)
      mmio_word = {24'h0, gpio_out};
    else if (mmio_off < 32'd8)
      mmio_word = {24'h0, gpio_in};
    else
      mmio_word = 32'h0;
  end

  assign accept = req_valid && req_ready;
  assign ram_en = (state == IDLE) && req_valid && ram_hit && !err;
  assign ram_we = (ram_en && req_we) ? lane_mask : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = (!req_we && ram_hit && !err) ? RD_WAIT : RESP;
      end
      RD_WAIT: state_next = RESP;
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      gpio_out  <= 8'h0;
      lat_lane  <= 2'b00;
      lat_f3    <= 3'b000;
    end else if (state == IDLE && accept) begin
      lat_lane <= req_addr[1:0];
      lat_f3   <= req_funct3;
      if (err) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b1;
      end else if (req_we) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b0;
        if (mmio_hit && mmio_off == 32'd0)
          gpio_out <= req_wdata[7:0];
      end else if (mmio_hit) begin
        rsp_rdata <= fmt_load(mmio_word, req_addr[1:0], req_funct3);
        rsp_err   <= 1'b0;
      end
      // RAM loads leave the previous response in place until RD_WAIT.
    end else if (state == RD_WAIT) begin
      rsp_rdata <= fmt_load(ram_rdata, lat_lane, lat_f3);
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_map.sv
// tb/tb_lsu_mem_map.sv - self-checking bench for lsu_mem_map
module tb_lsu_mem_map;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [7:0]  gpio_out, gpio_in;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb[$];
  logic [31:0] mem [256];

  logic        s_ready, s_en;
  logic [3:0]  s_we;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;

  lsu_mem_map #(.DATA_MEM_DEPTH(1024), .MMIO_MEM_SIZE(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard: every response pops the oldest expectation {err, rdata}.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got err=%b rdata=%h exp no response", rsp_err, rsp_rdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({rsp_err, rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp got err=%b rdata=%h exp err=%b rdata=%h",
                   rsp_err, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    s_ready = req_ready; s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 8);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; gpio_in = 8'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", rsp_err); end
    checks++;
    if (gpio_out !== 8'h0) begin errors++; $display("FAIL rst_gpio got %h exp 0", gpio_out); end
  endtask

  task automatic test_store_word();
    int lat;
    sb.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b010, 32'h1001_0000, 32'hDEAD_BEEF, lat);
    checks++;
    if ({s_ready, s_en, s_we, s_addr, s_wdata} !== {1'b1, 1'b1, 4'hF, 8'd0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL sw_ram got rdy=%b en=%b we=%b addr=%0d wd=%h exp 1 1 1111 0 deadbeef",
               s_ready, s_en, s_we, s_addr, s_wdata);
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", lat); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5];
    logic [31:0] ad [5];
    logic [31:0] ex [5];
    int lat;
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ad = '{32'h1001_0003, 32'h1001_0003, 32'h1001_0002, 32'h1001_0000, 32'h1001_0000};
    ex = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      sb.push_back({1'b0, ex[i]});
      issue(1'b0, f3[i], ad[i], 32'h0, lat);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL load_latency[%0d] got %0d exp 2", i, lat); end
    end
  endtask

  task automatic test_stack();
    int lat;
    sb.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b010, 32'h7FFF_EFFC, 32'h1234_5678, lat);
    checks++;
    if ({s_en, s_we, s_addr} !== {1'b1, 4'hF, 8'd255}) begin
      errors++;
      $display("FAIL stack_sw got en=%b we=%b addr=%0d exp 1 1111 255", s_en, s_we, s_addr);
    end
    sb.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b000, 32'h7FFF_EE01, 32'h0000_00AB, lat);
    checks++;
    if ({s_en, s_we, s_addr, s_wdata} !== {1'b1, 4'b0010, 8'd128, 32'hABAB_ABAB}) begin
      errors++;
      $display("FAIL stack_sb got en=%b we=%b addr=%0d wd=%h exp 1 0010 128 abababab",
               s_en, s_we, s_addr, s_wdata);
    end
    sb.push_back({1'b0, 32'h1234_5678});
    issue(1'b0, 3'b010, 32'h7FFF_EFFC, 32'h0, lat);
    sb.push_back({1'b0, 32'h0000_00AB});
    issue(1'b0, 3'b100, 32'h7FFF_EE01, 32'h0, lat);
  endtask

  task automatic test_mmio();
    int lat;
    sb.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b000, 32'h1001_0024, 32'h0000_005A, lat);
    checks++;
    if ({gpio_out, s_en, lat[3:0]} !== {8'h5A, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL mmio_sb got gpio=%h en=%b lat=%0d exp 5a 0 1", gpio_out, s_en, lat);
    end
    gpio_in = 8'h3C;
    sb.push_back({1'b0, 32'h0000_003C});
    issue(1'b0, 3'b010, 32'h1001_0028, 32'h0, lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL mmio_lw_latency got %0d exp 1", lat); end
    sb.push_back({1'b0, 32'h0000_005A});
    issue(1'b0, 3'b100, 32'h1001_0024, 32'h0, lat);
    sb.push_back({1'b0, 32'h0});
    issue(1'b1, 3'b010, 32'h1001_0028, 32'hFFFF_FFFF, lat);
    checks++;
    if (gpio_out !== 8'h5A) begin errors++; $display("FAIL mmio_ro_write got %h exp 5a", gpio_out); end
  endtask

  task automatic test_errors();
    logic        we [6];
    logic [2:0]  f3 [6];
    logic [31:0] ad [6];
    int lat;
    we = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    f3 = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
    ad = '{32'h1001_0002, 32'h1001_0001, 32'h0000_0000, 32'h1001_0000, 32'h1001_0000, 32'h1001_0025};
    for (int i = 0; i < 6; i++) begin
      sb.push_back({1'b1, 32'h0});
      issue(we[i], f3[i], ad[i], 32'h0000_00FF, lat);
      checks++;
      if ({s_en, s_we, gpio_out, lat[3:0]} !== {1'b0, 4'h0, 8'h5A, 4'd1}) begin
        errors++;
        $display("FAIL err_case[%0d] got en=%b we=%b gpio=%h lat=%0d exp 0 0000 5a 1",
                 i, s_en, s_we, gpio_out, lat);
      end
    end
  endtask

  task automatic test_rst_rd_wait();
    int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1001_0000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, req_ready, gpio_out} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL rst_in_rd_wait got valid=%b ready=%b gpio=%h exp 0 1 00",
               rsp_valid, req_ready, gpio_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL dropped_rsp got %0d pulses exp 0", seen); end
    sb.push_back({1'b0, 32'hDEAD_BEEF});
    issue(1'b0, 3'b010, 32'h1001_0000, 32'h0, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL post_rst_lw_latency got %0d exp 2", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [8];
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[i] = d;
      sb.push_back({1'b0, 32'h0});
      issue(1'b1, 3'b010, 32'h7FFF_EE00 + 32'(4 * i), d, lat);
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[i][15:8] = d[7:0];
      sb.push_back({1'b0, 32'h0});
      issue(1'b1, 3'b000, 32'h7FFF_EE01 + 32'(4 * i), d, lat);
    end
    for (int i = 0; i < 8; i++) begin
      sb.push_back({1'b0, model[i]});
      issue(1'b0, 3'b010, 32'h7FFF_EE00 + 32'(4 * i), 32'h0, lat);
      sb.push_back({{17{model[i][31]}}, model[i][31:16]});
      sb[sb.size()-1][32] = 1'b0;
      issue(1'b0, 3'b001, 32'h7FFF_EE02 + 32'(4 * i), 32'h0, lat);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_stack();
    test_mmio();
    test_errors();
    test_rst_rd_wait();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL missing_rsp got %0d pending exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
